// File: rtl/sk9822_frame_tx.sv
// SK9822 strip serialiser: fetches one word per LED from the register bank and shifts out start/LED/end frames.
// Build option: define SK9822_CONT_REFRESH_EN for continuous refresh (DONE loops straight back to START).
module sk9822_frame_tx #(
    parameter int NUM_LEDS = 30,
    parameter int CLK_DIV  = 4,
    parameter int END_BITS = 48,
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    input  logic          start,
    output logic          led_rd_en,
    output logic [AW-1:0] led_rd_addr,
    input  logic [31:0]   led_rd_data,
    output logic          busy,
    output logic          done,
    output logic          sck,
    output logic          sdo
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int BW = $clog2(END_BITS);
    localparam logic [DW-1:0] DIV_HALF      = DW'(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST      = DW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_WORD_BIT = BW'(31);
    localparam logic [BW-1:0] LAST_END_BIT  = BW'(END_BITS - 1);
    localparam logic [AW-1:0] LAST_ADDR     = AW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FETCH,
        ST_LED,
        ST_END,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   shift_q, shift_d;
    logic          fetch_q, fetch_d;
    logic          done_q, done_d;
    logic          cell_end;
    logic          serial;
    logic          unused_rd_bits;

    // Bits [31:29] of the bank word are replaced by the fixed 3'b111 frame marker.
    assign unused_rd_bits = ^led_rd_data[31:29];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            fetch_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            fetch_q <= fetch_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        fetch_d  = fetch_q;
        done_d   = 1'b0;
        cell_end = (div_q == DIV_LAST);
        if (state_q inside {ST_START, ST_LED, ST_END}) begin
            div_d = cell_end ? '0 : div_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    div_d   = '0;
                    bit_d   = '0;
                    addr_d  = '0;
                    shift_d = '0;
                    fetch_d = 1'b0;
                end
            end
            ST_START: begin
                if (cell_end) begin
                    if (bit_q == LAST_WORD_BIT) begin
                        bit_d   = '0;
                        addr_d  = '0;
                        fetch_d = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            // Two low cycles: strobe the read, then capture the word one cycle later.
            ST_FETCH: begin
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    shift_d = {3'b111, led_rd_data[28:0]};
                    state_d = ST_LED;
                end
            end
            ST_LED: begin
                if (cell_end) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    if (bit_q == LAST_WORD_BIT) begin
                        bit_d = '0;
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_END;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_END: begin
                if (cell_end) begin
                    if (bit_q == LAST_END_BIT) begin
                        bit_d  = '0;
                        done_d = 1'b1;
`ifdef SK9822_CONT_REFRESH_EN
                        state_d = ST_START;
                        shift_d = '0;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // In continuous mode done pulses during the first START cycle, keeping the frame period unchanged.
    assign serial      = state_q inside {ST_START, ST_LED, ST_END};
    assign sck         = serial && (div_q >= DIV_HALF);
    assign sdo         = serial && shift_q[31];
    assign done        = done_q;
    assign led_rd_en   = (state_q == ST_FETCH) && !fetch_q;
    assign led_rd_addr = addr_q;
`ifdef SK9822_CONT_REFRESH_EN
    assign busy = (state_q != ST_IDLE);
`else
    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
`endif

endmodule

// File: tb/tb_sk9822_frame_tx.sv
// Directed bench for sk9822_frame_tx: bank model, SPI decoder and phase monitor on ACLK falling edges.
module tb_sk9822_frame_tx;

    localparam int NUM_LEDS  = 2;
    localparam int CLK_DIV   = 2;
    localparam int END_BITS  = 32;
    localparam int FRAME_LEN = 516;
    localparam int AW        = $clog2(NUM_LEDS);

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          start = 1'b0;
    logic          led_rd_en;
    logic [AW-1:0] led_rd_addr;
    logic [31:0]   led_rd_data = '0;
    logic          busy, done, sck, sdo;

    logic [31:0] mem [NUM_LEDS];

    int checks = 0;
    int errors = 0;

    int cyc = 0, nbits = 0, run_len = 0, bcnt = 0;
    int bad_phase = 0, hi_runs = 0, lo4_runs = 0, sdo_glitch = 0, idle_bad = 0;
    int rd_cnt = 0, done_cnt = 0;
    bit run_busy = 1'b0;
    logic sck_p = 1'b0, sdo_p = 1'b0;
    logic [31:0] acc = '0;
    logic [31:0] words[$];
    int busy_lens[$];
    int done_cyc[$];
    int addrs[$];

    sk9822_frame_tx #(
        .NUM_LEDS(NUM_LEDS),
        .CLK_DIV (CLK_DIV),
        .END_BITS(END_BITS)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .start      (start),
        .led_rd_en  (led_rd_en),
        .led_rd_addr(led_rd_addr),
        .led_rd_data(led_rd_data),
        .busy       (busy),
        .done       (done),
        .sck        (sck),
        .sdo        (sdo)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (led_rd_en) led_rd_data <= mem[led_rd_addr];
    end

    always @(negedge ACLK) begin
        cyc = cyc + 1;
        if (!busy) nbits = 0;
        else if (sck && !sck_p) begin
            acc = {acc[30:0], sdo};
            nbits = nbits + 1;
            if (nbits == 32) begin
                words.push_back(acc);
                nbits = 0;
            end
        end
        if (sck && sck_p && (sdo !== sdo_p)) sdo_glitch = sdo_glitch + 1;
        if (!busy && ((sck !== 1'b0) || (sdo !== 1'b0))) idle_bad = idle_bad + 1;
        if (sck === sck_p) begin
            run_len = run_len + 1;
            run_busy = run_busy && busy;
        end else begin
            if (run_busy && ARESETN) begin
                if (sck_p) begin
                    hi_runs = hi_runs + 1;
                    if (run_len != CLK_DIV) bad_phase = bad_phase + 1;
                end else if (run_len == 2 * CLK_DIV) lo4_runs = lo4_runs + 1;
                else if (run_len != CLK_DIV) bad_phase = bad_phase + 1;
            end
            run_len = 1;
            run_busy = busy;
        end
        if (led_rd_en) begin
            rd_cnt = rd_cnt + 1;
            addrs.push_back(int'(led_rd_addr));
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc.push_back(cyc);
        end
        if (busy) bcnt = bcnt + 1;
        else if (bcnt != 0) begin
            busy_lens.push_back(bcnt);
            bcnt = 0;
        end
        sck_p = sck;
        sdo_p = sdo;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge ACLK);
    endtask

    task automatic pulse_start();
        @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge ACLK);
        ok = (done === 1'b1);
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        wait_cycles(3);
        checks++;
        if ({sck, sdo, busy, done, led_rd_en, led_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs sck=%b sdo=%b busy=%b done=%b rd_en=%b addr=%0d want all 0",
                     sck, sdo, busy, done, led_rd_en, led_rd_addr);
        end
        ARESETN = 1'b1;
        wait_cycles(20);
        checks++;
        if (busy !== 1'b0 || hi_runs != 0 || rd_cnt != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL reset_quiet busy=%b hi_runs=%0d rd=%0d done=%0d want 0 0 0 0", busy, hi_runs, rd_cnt, done_cnt);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        int n0 = words.size();
        int b0 = busy_lens.size();
        int d0 = done_cnt;
        logic [31:0] exp_w [4] = '{32'h0000_0000, 32'hFFAA_5533, 32'hE112_3456, 32'h0000_0000};
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise busy=%b want 1", busy);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_done_timeout done not seen within 2000 cycles");
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL done_pulse busy=%b done=%b pulses=%0d want 0 0 1", busy, done, done_cnt - d0);
        end
        checks++;
        if (busy_lens.size() != b0 + 1 || busy_lens[b0] != FRAME_LEN) begin
            errors++;
            $display("FAIL busy_len got %0d want %0d", busy_lens[b0], FRAME_LEN);
        end
        checks++;
        if (words.size() != n0 + 4) begin
            errors++;
            $display("FAIL word_count got %0d want 4", words.size() - n0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (words[n0 + i] !== exp_w[i]) begin
                errors++;
                $display("FAIL frame_word%0d got %h want %h", i, words[n0 + i], exp_w[i]);
            end
        end
    endtask

    task automatic test_read_port();
        bit ok;
        int r0 = rd_cnt;
        int a0 = addrs.size();
        int n0 = words.size();
        pulse_start();
        for (int i = 0; i < 300 && rd_cnt < r0 + 1; i++) @(negedge ACLK);
        wait_cycles(20);
        mem[1] = 32'h8765_4321;
        for (int i = 0; i < 300 && rd_cnt < r0 + 2; i++) @(negedge ACLK);
        wait_cycles(20);
        mem[1] = 32'h1F00_FF00;
        wait_done(ok);
        checks++;
        if (!ok || rd_cnt - r0 != 2) begin
            errors++;
            $display("FAIL rd_strobes got %0d done_ok=%0b want 2", rd_cnt - r0, ok);
        end
        checks++;
        if (addrs[a0] != 0 || addrs[a0 + 1] != 1) begin
            errors++;
            $display("FAIL rd_addrs got %0d,%0d want 0,1", addrs[a0], addrs[a0 + 1]);
        end
        checks++;
        if (words[n0 + 2] !== 32'hE765_4321) begin
            errors++;
            $display("FAIL fetch_before_read got %h want e7654321", words[n0 + 2]);
        end
        pulse_start();
        wait_done(ok);
        checks++;
        if (!ok || words[n0 + 6] !== 32'hFF00_FF00 || words[n0 + 5] !== 32'hFFAA_5533) begin
            errors++;
            $display("FAIL snapshot_next_frame led0=%h led1=%h want ffaa5533 ff00ff00", words[n0 + 5], words[n0 + 6]);
        end
        mem[1] = 32'h0112_3456;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int d0 = done_cnt;
        int b0 = busy_lens.size();
        pulse_start();
        wait_cycles(98);
        pulse_start();
        wait_done(ok);
        wait_cycles(30);
        checks++;
        if (!ok || done_cnt - d0 != 1 || busy !== 1'b0 || busy_lens.size() != b0 + 1 || busy_lens[b0] != FRAME_LEN) begin
            errors++;
            $display("FAIL start_while_busy dones=%0d busy=%b frames=%0d len=%0d want 1 0 1 %0d",
                     done_cnt - d0, busy, busy_lens.size() - b0, busy_lens[b0], FRAME_LEN);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n0 = words.size();
        int b0 = busy_lens.size();
        @(negedge ACLK);
        start = 1'b1;
        for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge ACLK);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done timeout");
        end
        @(negedge ACLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap busy=%b want 0", busy);
        end
        @(negedge ACLK);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart busy=%b want 1", busy);
        end
        wait_done(ok);
        wait_cycles(5);
        checks++;
        if (!ok || busy_lens.size() != b0 + 2 || busy_lens[b0 + 1] != FRAME_LEN || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frames count=%0d len=%0d busy=%b want 2 %0d 0",
                     busy_lens.size() - b0, busy_lens[b0 + 1], busy, FRAME_LEN);
        end
        checks++;
        if (words[n0 + 5] !== 32'hFFAA_5533 || words[n0 + 6] !== 32'hE112_3456) begin
            errors++;
            $display("FAIL b2b_words got %h %h want ffaa5533 e1123456", words[n0 + 5], words[n0 + 6]);
        end
    endtask

    task automatic test_timing();
        bit ok;
        int h0 = hi_runs;
        int l0 = lo4_runs;
        pulse_start();
        wait_done(ok);
        checks++;
        if (!ok || hi_runs - h0 != 128 || lo4_runs - l0 != NUM_LEDS) begin
            errors++;
            $display("FAIL phase_counts high=%0d fetch_lows=%0d want 128 %0d", hi_runs - h0, lo4_runs - l0, NUM_LEDS);
        end
        checks++;
        if (bad_phase != 0 || sdo_glitch != 0 || idle_bad != 0) begin
            errors++;
            $display("FAIL phase_rules bad_len=%0d sdo_in_high=%0d idle_active=%0d want 0 0 0",
                     bad_phase, sdo_glitch, idle_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int h0, r0;
        pulse_start();
        wait_cycles(150);
        for (int i = 0; i < 20 && sck !== 1'b1; i++) @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if (sck !== 1'b0 || sdo !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort sck=%b sdo=%b busy=%b done=%b want 0 0 0 0", sck, sdo, busy, done);
        end
        wait_cycles(2);
        ARESETN = 1'b1;
        h0 = hi_runs;
        r0 = rd_cnt;
        wait_cycles(100);
        checks++;
        if (busy !== 1'b0 || hi_runs != h0 || rd_cnt != r0) begin
            errors++;
            $display("FAIL abort_quiet busy=%b new_high=%0d new_rd=%0d want 0 0 0", busy, hi_runs - h0, rd_cnt - r0);
        end
    endtask

`ifdef SK9822_CONT_REFRESH_EN
    task automatic test_cont_refresh();
        int b0 = busy_lens.size();
        int c0 = done_cyc.size();
        int h0;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge ACLK);
            @(negedge ACLK);
            if (k == 1) pulse_start();
        end
        checks++;
        if (done_cyc.size() != c0 + 4) begin
            errors++;
            $display("FAIL cont_done_count got %0d want 4", done_cyc.size() - c0);
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (done_cyc[c0 + k] - done_cyc[c0 + k - 1] != FRAME_LEN) begin
                errors++;
                $display("FAIL cont_period%0d got %0d want %0d", k, done_cyc[c0 + k] - done_cyc[c0 + k - 1], FRAME_LEN);
            end
        end
        checks++;
        if (busy_lens.size() != b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_busy drops=%0d busy=%b want 0 1", busy_lens.size() - b0, busy);
        end
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if (sck !== 1'b0 || sdo !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_reset sck=%b sdo=%b busy=%b want 0 0 0", sck, sdo, busy);
        end
        wait_cycles(2);
        ARESETN = 1'b1;
        h0 = hi_runs;
        wait_cycles(100);
        checks++;
        if (busy !== 1'b0 || hi_runs != h0) begin
            errors++;
            $display("FAIL cont_stopped busy=%b new_high=%0d want 0 0", busy, hi_runs - h0);
        end
    endtask
`endif

    initial begin
        mem[0] = 32'hFFAA_5533;
        mem[1] = 32'h0112_3456;
        test_reset();
`ifdef SK9822_CONT_REFRESH_EN
        test_cont_refresh();
`else
        test_single_frame();
        test_read_port();
        test_start_ignored();
        test_back_to_back();
        test_timing();
        test_reset_mid_frame();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
